// File: rtl/hack_fetch_ctrl_pkg.sv
// Shared definitions for the Hack fetch/branch sequencer: widths, jump-field
// bit positions and FSM state encodings.
package hack_fetch_ctrl_pkg;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;

    // C-instruction marker and jump bits (j1 = less-than, j2 = equal, j3 = greater-than)
    localparam int C_BIT   = 15;
    localparam int JLT_BIT = 2;
    localparam int JEQ_BIT = 1;
    localparam int JGT_BIT = 0;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_EXEC     = 3'd3,
        ST_UPDATE   = 3'd4,
        ST_HALT     = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

endpackage

// File: rtl/hack_fetch_ctrl_jump_eval.sv
// Combinational jump resolution from the C-instruction jump bits and ALU flags.
// Also used by the ALU trace checker, so it stays free of any sequencing state.
module hack_jump_eval
    import hack_fetch_ctrl_pkg::*;
(
    input  logic       is_c,
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = is_c & ((jmp[JLT_BIT] & ng) |
                          (jmp[JEQ_BIT] & zr) |
                          (jmp[JGT_BIT] & ~ng & ~zr));

endmodule

// File: rtl/hack_fetch_ctrl.sv
// Fetch/branch sequencer for the Hack CPU: fetches from ROM over req/ack,
// hands the word to execute, then strobes the pc with either a load or an increment.
module hack_fetch_ctrl
    import hack_fetch_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int ROM_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_val,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              zr,
    input  logic              ng,
    input  logic [ADDR_W-1:0] a_val,
    output logic              halted,
    output logic              fault
);

    localparam logic [7:0] HOLD_LAST    = 8'(RESET_CYCLES);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ROM_TIMEOUT - 1);

    state_e            state_r, state_nxt;
    logic [7:0]        hold_cnt_r, hold_cnt_nxt;
    logic [7:0]        wait_cnt_r, wait_cnt_nxt;
    logic [WORD_W-1:0] instr_r, instr_nxt;
    logic [ADDR_W-1:0] tgt_r, tgt_nxt;
    logic [ADDR_W-1:0] rom_addr_r, rom_addr_nxt;
    logic              rom_req_r, rom_req_nxt;
    logic              instr_valid_r, instr_valid_nxt;
    logic              pc_load_r, pc_load_nxt;
    logic              pc_inc_r, pc_inc_nxt;
    logic              halt_pend_r, halt_pend_nxt;
    logic              halted_r, halted_nxt;
    logic              fault_r, fault_nxt;
    logic              take_s;
    logic              halt_hit_s;

    hack_jump_eval u_jump_eval (
        .is_c (instr_r[C_BIT]),
        .jmp  (instr_r[2:0]),
        .zr   (zr),
        .ng   (ng),
        .take (take_s)
    );

    assign halt_hit_s = take_s & (instr_r[2:0] == 3'b111) & (a_val == rom_addr_r);

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_nxt       = state_r;
        hold_cnt_nxt    = hold_cnt_r;
        wait_cnt_nxt    = wait_cnt_r;
        instr_nxt       = instr_r;
        tgt_nxt         = tgt_r;
        rom_addr_nxt    = rom_addr_r;
        rom_req_nxt     = rom_req_r;
        instr_valid_nxt = 1'b0;
        pc_load_nxt     = 1'b0;
        pc_inc_nxt      = 1'b0;
        halt_pend_nxt   = halt_pend_r;
        halted_nxt      = halted_r;
        fault_nxt       = fault_r;
        case (state_r)
            ST_RST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt_r + 8'd1;
                end
            end
            ST_IDLE: begin
                if (run) begin
                    state_nxt    = ST_FETCH;
                    rom_req_nxt  = 1'b1;
                    rom_addr_nxt = pc_val;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An ack on the final wait cycle is checked first so it beats the timeout
                if (rom_ack) begin
                    state_nxt       = ST_EXEC;
                    instr_nxt       = rom_data;
                    instr_valid_nxt = 1'b1;
                    rom_req_nxt     = 1'b0;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_nxt   = ST_FAULT;
                    rom_req_nxt = 1'b0;
                    fault_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt_r + 8'd1;
                end
            end
            ST_EXEC: begin
                // Strobes are decided here so they are high during the UPDATE cycle itself
                if (exec_done) begin
                    state_nxt     = ST_UPDATE;
                    tgt_nxt       = a_val;
                    pc_load_nxt   = take_s & ~halt_hit_s;
                    pc_inc_nxt    = ~take_s;
                    halt_pend_nxt = halt_hit_s;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_UPDATE: begin
                if (halt_pend_r) begin
                    state_nxt  = ST_HALT;
                    halted_nxt = 1'b1;
                end else if (run) begin
                    // pc updates on this same edge, so fetch from the value it is about to take
                    state_nxt    = ST_FETCH;
                    rom_req_nxt  = 1'b1;
                    rom_addr_nxt = pc_load_r ? tgt_r : pc_val + 15'd1;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt   = ST_RST_HOLD;
                rom_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset clears every output at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RST_HOLD;
            hold_cnt_r    <= 8'd0;
            wait_cnt_r    <= 8'd0;
            instr_r       <= 16'd0;
            tgt_r         <= 15'd0;
            rom_addr_r    <= 15'd0;
            rom_req_r     <= 1'b0;
            instr_valid_r <= 1'b0;
            pc_load_r     <= 1'b0;
            pc_inc_r      <= 1'b0;
            halt_pend_r   <= 1'b0;
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            hold_cnt_r    <= hold_cnt_nxt;
            wait_cnt_r    <= wait_cnt_nxt;
            instr_r       <= instr_nxt;
            tgt_r         <= tgt_nxt;
            rom_addr_r    <= rom_addr_nxt;
            rom_req_r     <= rom_req_nxt;
            instr_valid_r <= instr_valid_nxt;
            pc_load_r     <= pc_load_nxt;
            pc_inc_r      <= pc_inc_nxt;
            halt_pend_r   <= halt_pend_nxt;
            halted_r      <= halted_nxt;
            fault_r       <= fault_nxt;
        end
    end

    assign pc_load     = pc_load_r;
    assign pc_inc      = pc_inc_r;
    assign pc_target   = tgt_r;
    assign rom_req     = rom_req_r;
    assign rom_addr    = rom_addr_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;
    assign fault       = fault_r;

endmodule
